// File: rtl/acq_pkg.sv
// acq_pkg: shared state, trigger-type and sample-width definitions for the acquisition trigger sequencer.
package acq_pkg;
    localparam int SAMPLE_W = 12;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_LO = 3'd1,
        WAIT_HI = 3'd2,
        CAPTURE = 3'd3,
        HOLD    = 3'd4
    } state_t;
    localparam logic [1:0] TRIG_IMM  = 2'd0;
    localparam logic [1:0] TRIG_RISE = 2'd1;
    localparam logic [1:0] TRIG_FALL = 2'd2;
    localparam logic [1:0] TRIG_EXT  = 2'd3;
    function automatic state_t entry_state(input logic [1:0] t);
        return t == TRIG_IMM ? CAPTURE : t == TRIG_EXT ? WAIT_HI : WAIT_LO;
    endfunction
endpackage

// File: rtl/acq_trigger_sequencer_if.sv
// acq_trigger_sequencer_if: event FIFO write-side handshake between sequencer and FIFO.
interface acq_trigger_sequencer_if;
    logic fifo_wr;
    logic fifo_full;
    modport master (output fifo_wr, input fifo_full);
    modport slave (input fifo_wr, output fifo_full);
endinterface

// File: rtl/toggle_sync.sv
// toggle_sync: brings a toggle from another clock domain into clklvds and emits a one-cycle pulse per edge.
module toggle_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clklvds,
    input  logic rstn,
    input  logic tgl,
    output logic pulse
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    always_ff @(posedge clklvds or negedge rstn)
        if (!rstn) begin
            sync  <= '0;
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], tgl};
            prev  <= sync[SYNC_STAGES-1];
            pulse <= sync[SYNC_STAGES-1] ^ prev;
        end
endmodule

// File: rtl/acq_trigger_sequencer.sv
// acq_trigger_sequencer: arms, qualifies a trigger, bursts one event into the FIFO and holds it for readout.
module acq_trigger_sequencer
    import acq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int LEN_W       = 16,
    parameter int TMO_W       = 24
) (
    input  logic                       clklvds,
    input  logic                       rstn,
    input  logic                       arm_tgl,
    input  logic                       rdone_tgl,
    input  logic [1:0]                 cfg_trigtype,
    input  logic signed [SAMPLE_W-1:0] cfg_lower,
    input  logic signed [SAMPLE_W-1:0] cfg_upper,
    input  logic [LEN_W-1:0]           cfg_length,
    input  logic [TMO_W-1:0]           cfg_timeout,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       ext_trig,
    acq_trigger_sequencer_if.master    fifo,
    output logic [LEN_W-1:0]           wr_count,
    output logic [LEN_W-1:0]           event_count,
    output logic [2:0]                 state_o,
    output logic                       timed_out,
    output logic                       overflow
);
    state_t                     state;
    logic                       arm, rdone;
    logic [1:0]                 typ;
    logic signed [SAMPLE_W-1:0] lower, upper;
    logic [LEN_W-1:0]           length;
    logic [TMO_W-1:0]           timeout, tmo;
    logic                       lo_hit, hi_hit, tmo_hit, room;

    toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_arm_sync (
        .clklvds(clklvds), .rstn(rstn), .tgl(arm_tgl), .pulse(arm)
    );
    toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rdone_sync (
        .clklvds(clklvds), .rstn(rstn), .tgl(rdone_tgl), .pulse(rdone)
    );

    assign state_o = state;
    assign lo_hit  = typ == TRIG_RISE ? sample_in < lower : sample_in > upper;
    assign hi_hit  = typ == TRIG_EXT ? ext_trig : typ == TRIG_RISE ? sample_in > upper : sample_in < lower;
    assign tmo_hit = timeout != '0 && tmo == timeout - TMO_W'(1);
    assign room    = !fifo.fifo_full && wr_count < length;

    always_ff @(posedge clklvds or negedge rstn)
        if (!rstn) begin
            state       <= IDLE;
            typ         <= TRIG_IMM;
            lower       <= '0;
            upper       <= '0;
            length      <= '0;
            timeout     <= '0;
            tmo         <= '0;
            fifo.fifo_wr <= 1'b0;
            wr_count    <= '0;
            event_count <= '0;
            timed_out   <= 1'b0;
            overflow    <= 1'b0;
        end else if (arm && state inside {IDLE, WAIT_LO, WAIT_HI}) begin
            typ     <= cfg_trigtype;
            lower   <= cfg_lower;
            upper   <= cfg_upper;
            length  <= cfg_length;
            timeout <= cfg_timeout;
            tmo     <= '0;
            state   <= entry_state(cfg_trigtype);
            if (state == IDLE) begin
                wr_count  <= '0;
                timed_out <= 1'b0;
                overflow  <= 1'b0;
            end
        end else begin
            case (state)
                WAIT_LO, WAIT_HI: begin
                    tmo <= tmo + TMO_W'(1);
                    // a real trigger takes precedence over a coincident timeout
                    if (state == WAIT_LO ? lo_hit : hi_hit)
                        state <= state == WAIT_LO ? WAIT_HI : CAPTURE;
                    else if (tmo_hit) begin
                        state     <= CAPTURE;
                        timed_out <= 1'b1;
                    end
                end
                CAPTURE:
                    if (room) begin
                        fifo.fifo_wr <= 1'b1;
                        wr_count     <= wr_count + LEN_W'(1);
                    end else begin
                        fifo.fifo_wr <= 1'b0;
                        event_count  <= event_count + LEN_W'(1);
                        overflow     <= wr_count < length;
                        state        <= HOLD;
                    end
                HOLD:
                    if (rdone) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_acq_trigger_sequencer.sv
// tb_acq_trigger_sequencer: directed scenarios with hand-computed expectations for the trigger sequencer.
module tb_acq_trigger_sequencer;
    logic               clklvds = 0;
    logic               rstn = 0;
    logic               arm_tgl = 0, rdone_tgl = 0;
    logic [1:0]         cfg_trigtype = 0;
    logic signed [11:0] cfg_lower = 0, cfg_upper = 0, sample_in = 0;
    logic [15:0]        cfg_length = 0;
    logic [23:0]        cfg_timeout = 0;
    logic               ext_trig = 0;
    logic [15:0]        wr_count, event_count;
    logic [2:0]         state_o;
    logic               timed_out, overflow;
    int                 checks = 0, errors = 0;
    int                 exp_ev = 0;

    acq_trigger_sequencer_if fifo ();

    acq_trigger_sequencer dut (
        .clklvds(clklvds), .rstn(rstn), .arm_tgl(arm_tgl), .rdone_tgl(rdone_tgl),
        .cfg_trigtype(cfg_trigtype), .cfg_lower(cfg_lower), .cfg_upper(cfg_upper),
        .cfg_length(cfg_length), .cfg_timeout(cfg_timeout), .sample_in(sample_in),
        .ext_trig(ext_trig), .fifo(fifo), .wr_count(wr_count), .event_count(event_count),
        .state_o(state_o), .timed_out(timed_out), .overflow(overflow)
    );

    always #5 clklvds = ~clklvds;

    task automatic tick();
        @(posedge clklvds);
        #1;
    endtask

    // n = ticks until state_o == s, or -1 if the budget expired
    task automatic wait_state(input logic [2:0] s, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (state_o == s) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic config_arm(input logic [1:0] t, input int lo, input int hi, input int len, input int tmo);
        cfg_trigtype = t;
        cfg_lower    = 12'(lo);
        cfg_upper    = 12'(hi);
        cfg_length   = 16'(len);
        cfg_timeout  = 24'(tmo);
        arm_tgl      = ~arm_tgl;
    endtask

    task automatic readout(input string name);
        int n;
        rdone_tgl = ~rdone_tgl;
        wait_state(3'd0, 20, n);
        checks++;
        if (n < 0) begin
            errors++;
            $display("FAIL %s_rdone_idle: state=%0d required=0", name, state_o);
        end
    endtask

    task automatic test_reset();
        rstn = 0;
        repeat (2) tick();
        rstn = 1;
        tick();
        checks++;
        if ({state_o, fifo.fifo_wr, wr_count, event_count, timed_out, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: state=%0d wr=%b wc=%0d ec=%0d to=%b ov=%b required all 0",
                     state_o, fifo.fifo_wr, wr_count, event_count, timed_out, overflow);
        end
    endtask

    task automatic test_immediate();
        int writes = 0;
        config_arm(2'd0, 0, 0, 5, 0);
        for (int i = 0; i < 25; i++) begin
            tick();
            writes += fifo.fifo_wr;
        end
        exp_ev++;
        checks++;
        if (writes != 5) begin
            errors++;
            $display("FAIL imm_writes: got=%0d required=5", writes);
        end
        checks++;
        if (event_count !== 16'(exp_ev) || state_o !== 3'd4 || wr_count !== 16'd5 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL imm_final: ec=%0d state=%0d wc=%0d ov=%b required ec=%0d state=4 wc=5 ov=0",
                     event_count, state_o, wr_count, overflow, exp_ev);
        end
        readout("imm");
    endtask

    task automatic test_rising();
        int n;
        sample_in = 0;
        config_arm(2'd1, -10, 10, 1, 0);
        wait_state(3'd1, 20, n);
        sample_in = 11;
        repeat (4) tick();
        checks++;
        if (n < 0 || state_o !== 3'd1) begin
            errors++;
            $display("FAIL rise_no_early: state=%0d required=1", state_o);
        end
        sample_in = 5;
        tick();
        sample_in = -11;
        tick();
        sample_in = 5;
        repeat (3) tick();
        checks++;
        if (state_o !== 3'd2) begin
            errors++;
            $display("FAIL rise_qualified: state=%0d required=2", state_o);
        end
        sample_in = 11;
        tick();
        checks++;
        if (state_o !== 3'd3) begin
            errors++;
            $display("FAIL rise_capture: state=%0d required=3", state_o);
        end
        sample_in = 0;
        wait_state(3'd4, 20, n);
        exp_ev++;
        readout("rise");
    endtask

    task automatic test_timeout();
        int n;
        sample_in = 0;
        config_arm(2'd2, -10, 10, 1, 100);
        wait_state(3'd1, 20, n);
        wait_state(3'd3, 200, n);
        checks++;
        if (n != 100) begin
            errors++;
            $display("FAIL tmo_cycles: got=%0d required=100", n);
        end
        checks++;
        if (timed_out !== 1'b1) begin
            errors++;
            $display("FAIL tmo_flag: got=%b required=1", timed_out);
        end
        wait_state(3'd4, 20, n);
        exp_ev++;
        readout("tmo");
    endtask

    task automatic test_overflow();
        int n = -1;
        config_arm(2'd0, 0, 0, 8, 0);
        for (int i = 0; i < 30; i++) begin
            tick();
            if (wr_count == 16'd3) begin
                n = i;
                break;
            end
        end
        fifo.fifo_full = 1;
        repeat (2) tick();
        exp_ev++;
        checks++;
        if (n < 0 || state_o !== 3'd4 || wr_count !== 16'd3 || overflow !== 1'b1 || event_count !== 16'(exp_ev)) begin
            errors++;
            $display("FAIL ovf_final: state=%0d wc=%0d ov=%b ec=%0d required state=4 wc=3 ov=1 ec=%0d",
                     state_o, wr_count, overflow, event_count, exp_ev);
        end
        fifo.fifo_full = 0;
        readout("ovf");
    endtask

    task automatic test_async_reset();
        int n, writes = 0;
        config_arm(2'd3, 0, 0, 2, 0);
        wait_state(3'd2, 20, n);
        #2;
        rstn = 0;
        arm_tgl = 0;
        rdone_tgl = 0;
        #1;
        checks++;
        if (n < 0 || {state_o, fifo.fifo_wr, wr_count, event_count, timed_out, overflow} !== '0) begin
            errors++;
            $display("FAIL rst_async: state=%0d wr=%b wc=%0d ec=%0d required all 0",
                     state_o, fifo.fifo_wr, wr_count, event_count);
        end
        exp_ev = 0;
        tick();
        rstn = 1;
        repeat (6) tick();
        config_arm(2'd3, 0, 0, 2, 0);
        wait_state(3'd2, 20, n);
        repeat (3) tick();
        ext_trig = 1;
        tick();
        ext_trig = 0;
        for (int i = 0; i < 10; i++) begin
            writes += fifo.fifo_wr;
            tick();
        end
        exp_ev++;
        checks++;
        if (writes != 2 || state_o !== 3'd4 || event_count !== 16'(exp_ev)) begin
            errors++;
            $display("FAIL ext_rearm: writes=%0d state=%0d ec=%0d required writes=2 state=4 ec=%0d",
                     writes, state_o, event_count, exp_ev);
        end
    endtask

    task automatic test_hold_and_tie();
        int n;
        arm_tgl = ~arm_tgl;
        repeat (8) tick();
        checks++;
        if (state_o !== 3'd4 || event_count !== 16'(exp_ev)) begin
            errors++;
            $display("FAIL hold_arm_drop: state=%0d ec=%0d required state=4 ec=%0d", state_o, event_count, exp_ev);
        end
        readout("hold");
        sample_in = -11;
        config_arm(2'd1, -10, 10, 1, 5);
        wait_state(3'd2, 20, n);
        repeat (3) tick();
        sample_in = 11;
        tick();
        checks++;
        if (n < 0 || state_o !== 3'd3 || timed_out !== 1'b0) begin
            errors++;
            $display("FAIL tie_trigger_wins: state=%0d to=%b required state=3 to=0", state_o, timed_out);
        end
        sample_in = 0;
        wait_state(3'd4, 20, n);
        readout("tie");
    endtask

    initial begin
        fifo.fifo_full = 0;
        test_reset();
        test_immediate();
        test_rising();
        test_timeout();
        test_overflow();
        test_async_reset();
        test_hold_and_tie();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
